// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file sequencer and its ALU.
package rf_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_CMP = 3'd6,
    OP_LDI = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // CMP only updates flags; every other op ends with a register write.
  function automatic logic writesBack(input op_t op);
    return op != OP_CMP;
  endfunction

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: result = a op b, with zero/negative/carry-borrow flags.
module rf_alu
  import rf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  op_t               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              z_o,
  output logic              n_o,
  output logic              c_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = '0;
    c_o      = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        c_o      = sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        result_o = a_i - b_i;
        c_o      = (a_i < b_i);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_MOV:  result_o = a_i;
      // LDI never reaches EXEC; its value is loaded directly by the sequencer.
      OP_LDI:  result_o = b_i;
      default: result_o = '0;
    endcase
    z_o = (result_o == '0);
    n_o = result_o[DATA_W-1];
  end

endmodule

// File: rtl/rf_sequencer.sv
// Sequencer that reads two registers, runs them through rf_alu and writes
// the result back through register-file port B, one instruction at a time.
module rf_sequencer
  import rf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  output logic              WR,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Src,
  input  logic [DATA_W-1:0] Dest,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  state_t            state_q, state_d;
  op_t               op_q;
  op_t               instrOp;
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;
  logic              cmpDone_q;
  logic              accept;

  logic [DATA_W-1:0] aluResult;
  logic              aluZ, aluN, aluC;

  assign instrOp = op_t'(instr_op);
  assign accept  = instr_valid && (state_q == IDLE);

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op_q),
    .a_i      (Src),
    .b_i      (Dest),
    .result_o (aluResult),
    .z_o      (aluZ),
    .n_o      (aluN),
    .c_o      (aluC)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (instrOp == OP_LDI) ? WRITE : READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = writesBack(op_q) ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    if (accept && instrOp == OP_LDI) begin
      result_d = instr_imm;
    end else if (state_q == EXEC) begin
      result_d = aluResult;
      z_d      = aluZ;
      n_d      = aluN;
      c_d      = aluC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      ra_q      <= '0;
      rb_q      <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      cmpDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      cmpDone_q <= (state_q == EXEC) && !writesBack(op_q);
      if (accept) begin
        op_q <= instrOp;
        ra_q <= instr_ra;
        rb_q <= instr_rb;
      end
    end
  end

  // RST masks WR and done so nothing escapes during the reset cycle itself.
  always_comb begin
    Addr_A  = '0;
    Addr_B  = '0;
    WR      = 1'b0;
    Data_in = '0;
    case (state_q)
      READ: begin
        Addr_A = ra_q;
        Addr_B = rb_q;
      end
      WRITE: begin
        Addr_B  = rb_q;
        WR      = !RST;
        Data_in = result_q;
      end
      default: ;
    endcase
  end

  assign done        = ((state_q == WRITE) || cmpDone_q) && !RST;
  assign instr_ready = (state_q == IDLE);
  assign result      = result_q;
  assign flag_z      = z_q;
  assign flag_n      = n_q;
  assign flag_c      = c_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench: behavioural register file plus an instruction-level
// reference model fed by directed and $urandom instruction streams.
module tb_rf_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, MOV = 3'd5, CMP = 3'd6, LDI = 3'd7;

  logic          CLK = 1'b0;
  logic          RST;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_ra, instr_rb;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] Addr_A, Addr_B;
  logic          WR;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Src, Dest;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_z, flag_n, flag_c;

  logic          memReset;
  logic [DW-1:0] rfMem [8];

  logic [DW-1:0] refRegs [8];
  logic [DW-1:0] refResult;
  logic          refZ, refN, refC;

  int totalChecks = 0;
  int badChecks   = 0;
  int wrPulses    = 0;
  int donePulses  = 0;

  always #5 CLK = ~CLK;

  rf_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .Addr_A      (Addr_A),
    .Addr_B      (Addr_B),
    .WR          (WR),
    .Data_in     (Data_in),
    .Src         (Src),
    .Dest        (Dest),
    .done        (done),
    .result      (result),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c)
  );

  // The register file keeps its contents across RST so abandoned writes stay visible.
  always @(posedge CLK) begin
    if (memReset) begin
      for (int i = 0; i < 8; i++) rfMem[i] <= '0;
      Src  <= '0;
      Dest <= '0;
    end else begin
      Src  <= rfMem[Addr_A[2:0]];
      Dest <= rfMem[Addr_B[2:0]];
      if (WR) rfMem[Addr_B[2:0]] <= Data_in;
    end
  end

  always @(negedge CLK) begin
    if (WR)   wrPulses++;
    if (done) donePulses++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Instruction-level semantics: each instruction applied atomically.
  task automatic modelExec(input logic [2:0] op, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [DW-1:0] imm);
    int a, b, r;
    a = refRegs[ra];
    b = refRegs[rb];
    if (op == LDI) begin
      refRegs[rb] = imm;
      refResult   = imm;
    end else begin
      refC = 1'b0;
      case (op)
        ADD:      begin r = a + b; refC = (r > 65535); end
        SUB, CMP: begin r = a - b; refC = (a < b);     end
        AND_:     r = a & b;
        OR_:      r = a | b;
        XOR_:     r = a ^ b;
        default:  r = a;
      endcase
      r = r & 32'hFFFF;
      refResult = r[15:0];
      refZ = (r == 0);
      refN = r[15];
      if (op != CMP) refRegs[rb] = r[15:0];
    end
  endtask

  task automatic checkState(input string tag, input logic [2:0] ra, input logic [2:0] rb);
    checkOutput({tag, "_regA"}, rfMem[ra], refRegs[ra]);
    checkOutput({tag, "_regB"}, rfMem[rb], refRegs[rb]);
    checkOutput({tag, "_result"}, result, refResult);
    checkOutput({tag, "_flags"}, {flag_z, flag_n, flag_c}, {refZ, refN, refC});
  endtask

  task automatic waitReady(output bit ok);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = instr_ready;
    if (!ok) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] ra,
                               input logic [2:0] rb, input logic [DW-1:0] imm);
    bit ok;
    int lat, wrBefore;
    @(negedge CLK);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_ra    = {1'b0, ra};
    instr_rb    = {1'b0, rb};
    instr_imm   = imm;
    waitReady(ok);
    if (!ok) begin
      instr_valid = 1'b0;
      return;
    end
    wrBefore = wrPulses;
    modelExec(op, ra, rb, imm);
    @(negedge CLK);
    instr_valid = 1'b0;
    instr_op    = 3'($urandom);
    instr_ra    = AW'($urandom);
    instr_rb    = AW'($urandom);
    instr_imm   = DW'($urandom);
    if (op == LDI) begin
      checkOutput("ldi_wr", WR, 1);
      checkOutput("ldi_addrB", Addr_B, rb);
      checkOutput("ldi_data", Data_in, imm);
      checkOutput("ldi_done", done, 1);
    end else begin
      checkOutput("read_addrA", Addr_A, ra);
      checkOutput("read_addrB", Addr_B, rb);
      checkOutput("read_wr", WR, 0);
      lat = 1;
      while (!done && lat < 8) begin
        @(negedge CLK);
        lat++;
      end
      checkOutput("latency", lat, 3);
      if (op == CMP) begin
        checkOutput("cmp_wr", WR, 0);
      end else begin
        checkOutput("wb_wr", WR, 1);
        checkOutput("wb_addrB", Addr_B, rb);
        checkOutput("wb_data", Data_in, refResult);
      end
    end
    @(negedge CLK);
    checkOutput("ready_after", instr_ready, 1);
    checkOutput("done_single", done, 0);
    checkOutput("wr_count", wrPulses - wrBefore, (op == CMP) ? 0 : 1);
    checkState("retire", ra, rb);
  endtask

  task automatic resetMidRead(input logic [2:0] ra, input logic [2:0] rb);
    bit ok;
    int wrBefore, doneBefore;
    @(negedge CLK);
    instr_valid = 1'b1;
    instr_op    = ADD;
    instr_ra    = {1'b0, ra};
    instr_rb    = {1'b0, rb};
    instr_imm   = '0;
    waitReady(ok);
    @(negedge CLK);
    instr_valid = 1'b0;
    wrBefore    = wrPulses;
    doneBefore  = donePulses;
    checkOutput("rst_read_addrA", Addr_A, ra);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("rst_idle", instr_ready, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_wr_low", WR, 0);
      checkOutput("rst_done_low", done, 0);
      @(negedge CLK);
    end
    refResult = '0;
    {refZ, refN, refC} = 3'b000;
    checkOutput("rst_wr_count", wrPulses - wrBefore, 0);
    checkOutput("rst_done_count", donePulses - doneBefore, 0);
    checkState("rst", ra, rb);
  endtask

  task automatic holdValid();
    int accepts = 0, wrBefore, doneBefore;
    logic [2:0] op, ra, rb;
    logic [DW-1:0] imm;
    wrBefore   = wrPulses;
    doneBefore = donePulses;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      op  = cyc[0] ? LDI : ADD;
      ra  = 3'($urandom_range(0, 7));
      rb  = 3'($urandom_range(0, 7));
      imm = DW'($urandom);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_ra    = {1'b0, ra};
      instr_rb    = {1'b0, rb};
      instr_imm   = imm;
      if (instr_ready) begin
        accepts++;
        modelExec(op, ra, rb, imm);
      end
    end
    @(negedge CLK);
    instr_valid = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("hold_wr_count", wrPulses - wrBefore, accepts);
    checkOutput("hold_done_count", donePulses - doneBefore, accepts);
    for (int i = 0; i < 8; i++) checkOutput("hold_reg", rfMem[i], refRegs[i]);
    checkOutput("hold_flags", {flag_z, flag_n, flag_c}, {refZ, refN, refC});
  endtask

  initial begin
    RST         = 1'b1;
    memReset    = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_ra    = '0;
    instr_rb    = '0;
    instr_imm   = '0;
    for (int i = 0; i < 8; i++) refRegs[i] = '0;
    refResult = '0;
    {refZ, refN, refC} = 3'b000;

    repeat (3) @(negedge CLK);
    checkOutput("reset_ready", instr_ready, 1);
    checkOutput("reset_wr", WR, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_addr", {Addr_A, Addr_B}, 0);
    checkOutput("reset_data", Data_in, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_flags", {flag_z, flag_n, flag_c}, 0);
    RST      = 1'b0;
    memReset = 1'b0;

    applyStimulus(LDI, 3'd0, 3'd3, 16'h1234);
    checkOutput("ldi_r3_value", rfMem[3], 16'h1234);

    applyStimulus(LDI, 3'd0, 3'd1, 16'h0005);
    applyStimulus(LDI, 3'd0, 3'd2, 16'h0003);
    applyStimulus(SUB, 3'd1, 3'd2, 16'h0000);
    checkOutput("sub_r2_value", rfMem[2], 16'h0002);
    checkOutput("sub_flags", {flag_z, flag_n, flag_c}, 3'b000);

    applyStimulus(LDI, 3'd0, 3'd1, 16'hFFFF);
    applyStimulus(LDI, 3'd0, 3'd2, 16'h0001);
    applyStimulus(ADD, 3'd1, 3'd2, 16'h0000);
    checkOutput("add_r2_value", rfMem[2], 16'h0000);
    checkOutput("add_flags", {flag_z, flag_n, flag_c}, 3'b101);

    applyStimulus(LDI, 3'd0, 3'd2, 16'h0003);
    applyStimulus(LDI, 3'd0, 3'd1, 16'h0005);
    applyStimulus(CMP, 3'd2, 3'd1, 16'h0000);
    checkOutput("cmp_r1_value", rfMem[1], 16'h0005);
    checkOutput("cmp_r2_value", rfMem[2], 16'h0003);
    checkOutput("cmp_flags", {flag_z, flag_n, flag_c}, 3'b011);

    applyStimulus(LDI, 3'd0, 3'd4, 16'h8001);
    applyStimulus(ADD, 3'd4, 3'd4, 16'h0000);
    checkOutput("same_reg_value", rfMem[4], 16'h0002);

    resetMidRead(3'd1, 3'd2);

    holdValid();

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), DW'($urandom));
    end
    for (int i = 0; i < 8; i++) checkOutput("final_reg", rfMem[i], refRegs[i]);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
